// File: rtl/led_frame_ctrl_if.sv
// UART-command / scanner bus for led_frame_ctrl: receive strobe and byte, scanner frame pulse
// and read port, plus the controller status outputs.
interface led_frame_ctrl_if #(
  parameter int unsigned NCOLS = 16
);
  localparam int unsigned COL_W = $clog2(NCOLS);

  logic             rx_dv;
  logic [7:0]       rx_byte;
  logic             frame_done;
  logic [COL_W-1:0] scan_col;
  logic [7:0]       scan_data;
  logic [2:0]       rgb;
  logic             swap_pending;
  logic             busy;
  logic             cmd_err;

  modport master (
    output rx_dv, rx_byte, frame_done, scan_col,
    input  scan_data, rgb, swap_pending, busy, cmd_err
  );

  modport slave (
    input  rx_dv, rx_byte, frame_done, scan_col,
    output scan_data, rgb, swap_pending, busy, cmd_err
  );
endinterface

// File: rtl/led_frame_ctrl.sv
// Command sequencer between the UART receiver and the LED panel scanner.
// Double-buffered frame store: UART commands fill the back bank, banks swap on frame_done.
module led_frame_ctrl #(
  parameter int unsigned NCOLS     = 16,
  parameter logic [2:0]  RGB_RESET = 3'b101
) (
  input  logic          clk,
  input  logic          reset,
  led_frame_ctrl_if.slave bus
);

  localparam int unsigned COL_W = $clog2(NCOLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WR_COL_DATA = 2'd1,
    WR_ALL_DATA = 2'd2,
    CLEAR       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W-1:0] idx_q, idx_d;
  logic [2:0]       rgb_q, rgb_d;
  logic [2:0]       rgb_staged_q, rgb_staged_d;
  logic             swap_pending_q, swap_pending_d;
  logic             disp_sel_q, disp_sel_d;
  logic             cmd_err_q, cmd_err_d;

  logic [7:0]       bank_q [2][NCOLS];

  logic             wr_en;
  logic [COL_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             swap_cmd;
  logic             take_swap;

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      col_q          <= '0;
      idx_q          <= '0;
      rgb_q          <= RGB_RESET;
      rgb_staged_q   <= RGB_RESET;
      swap_pending_q <= 1'b0;
      disp_sel_q     <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      idx_q          <= idx_d;
      rgb_q          <= rgb_d;
      rgb_staged_q   <= rgb_staged_d;
      swap_pending_q <= swap_pending_d;
      disp_sel_q     <= disp_sel_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  // Frame store; the back bank is taken from the pre-swap disp_sel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < int'(NCOLS); c++) begin
          bank_q[b][c] <= '0;
        end
      end
    end else if (wr_en) begin
      bank_q[~disp_sel_q][wr_addr] <= wr_data;
    end
  end

  // Command decode, data sequencing and swap control
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    idx_d          = idx_q;
    rgb_d          = rgb_q;
    rgb_staged_d   = rgb_staged_q;
    swap_pending_d = swap_pending_q;
    disp_sel_d     = disp_sel_q;
    cmd_err_d      = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    swap_cmd       = 1'b0;
    take_swap      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_dv) begin
          if (bus.rx_byte[7:4] == 4'h8) begin
            col_d   = COL_W'(bus.rx_byte[3:0]);
            state_d = WR_COL_DATA;
          end else if (bus.rx_byte == 8'h90) begin
            idx_d   = '0;
            state_d = WR_ALL_DATA;
          end else if (bus.rx_byte[7:3] == 5'b10100) begin
            rgb_staged_d = bus.rx_byte[2:0];
          end else if (bus.rx_byte == 8'hB0) begin
            swap_cmd = 1'b1;
          end else if (bus.rx_byte == 8'hC0) begin
            idx_d   = '0;
            state_d = CLEAR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      WR_COL_DATA: begin
        if (bus.rx_dv) begin
          wr_en   = 1'b1;
          wr_addr = col_q;
          wr_data = bus.rx_byte;
          state_d = IDLE;
        end
      end

      WR_ALL_DATA: begin
        if (bus.rx_dv) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          wr_data = bus.rx_byte;
          if (idx_q == LAST_COL) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + COL_W'(1);
          end
        end
      end

      CLEAR: begin
        // Clear runs autonomously; any byte arriving now is lost
        wr_en     = 1'b1;
        wr_addr   = idx_q;
        wr_data   = '0;
        cmd_err_d = bus.rx_dv;
        if (idx_q == LAST_COL) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + COL_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A swap only uses a request already pending before this frame_done
    take_swap = bus.frame_done && swap_pending_q;
    if (take_swap) begin
      disp_sel_d     = ~disp_sel_q;
      rgb_d          = rgb_staged_q;
      swap_pending_d = 1'b0;
    end
    if (swap_cmd) begin
      swap_pending_d = 1'b1;
    end
  end

  assign bus.scan_data    = bank_q[disp_sel_q][bus.scan_col];
  assign bus.rgb          = rgb_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.cmd_err      = cmd_err_q;

endmodule

// File: doc/led_frame_ctrl.md
Name: led_frame_ctrl

Overview:
- Command sequencer between the UART receiver and the LED panel scanner.
- Decodes received bytes into frame-buffer writes, colour changes, clears and buffer swaps.
- Owns a double-buffered 16x8-bit frame store: the scanner reads the display bank, UART commands write the back bank.
- Banks swap only on a scanner frame boundary, so the panel never shows a partial update.

Parameters:
- NCOLS, 16, frame columns (column address width is clog2(NCOLS) = 4).
- RGB_RESET, 3'b101, colour loaded into the active and staged colour registers at reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_dv  input  1  one-cycle strobe: rx_byte valid.
- rx_byte  input  8  received UART byte.
- frame_done  input  1  one-cycle pulse from the scanner after the last row of a frame.
- scan_col  input  4  scanner read address.
- scan_data  output  8  display-bank column scan_col; combinational, zero latency.
- rgb  output  3  active colour {r,g,b}.
- swap_pending  output  1  swap requested, not yet taken.
- busy  output  1  state != IDLE.
- cmd_err  output  1  one-cycle pulse on an invalid or dropped byte.

Behaviour:
- Reset values:
  - state = IDLE; both banks all zero; disp_sel = 0 (display bank 0, back bank 1).
  - rgb and rgb_staged = RGB_RESET.
  - swap_pending = 0; cmd_err = 0; busy = 0.
- Reset mid-command aborts the command. All of the above values apply on the next cycle.
- Register state/bank updates occur one cycle after rx_dv. scan_data reflects a bank write on the cycle after the write.
- Command decode in IDLE on rx_dv:
  - 0x80-0x8F (WR_COL): store col = byte[3:0]; go to WR_COL_DATA.
  - 0x90 (WR_ALL): idx = 0; go to WR_ALL_DATA.
  - 0xA0-0xA7 (SET_RGB): rgb_staged <= byte[2:0]; stay IDLE.
  - 0xB0 (SWAP): swap_pending <= 1; stay IDLE. Idempotent if already pending.
  - 0xC0 (CLEAR): idx = 0; go to CLEAR.
  - Any other value: cmd_err pulse; stay IDLE.
- WR_COL_DATA: the next rx_dv byte is written to back[col]; return to IDLE. Any byte value is data.
- WR_ALL_DATA:
  - Each rx_dv byte is written to back[idx], then idx increments.
  - After the write with idx = 15, return to IDLE (exactly 16 data bytes).
  - The 4-bit idx never wraps within a command.
- CLEAR:
  - Writes 0 to back[idx], one column per clk regardless of rx_dv; return to IDLE after idx = 15 (16 cycles).
  - An rx_dv during CLEAR is dropped and pulses cmd_err.
- Back bank is always ~disp_sel, evaluated on the cycle of each write. If a swap lands mid-WR_ALL, the remaining bytes go to the new back bank (documented, not an error).
- Swap: on a frame_done cycle with swap_pending = 1:
  - disp_sel toggles; rgb <= rgb_staged; swap_pending <= 0.
  - A SWAP byte decoded on the same cycle as frame_done does not swap on that frame_done: pending is set and the swap waits for the next frame_done.
  - frame_done with swap_pending = 0: no effect.
- A frame_done and a back-bank write on the same cycle: the write lands in the pre-toggle back bank.
- The scanner read port never stalls; there is no arbitration on the read path.
- cmd_err is a single-cycle pulse with no sticky state.

Test Plan:
- Reset, drive scan_col 0..15 -> scan_data = 0x00 for all columns; rgb = 3'b101; busy = 0; swap_pending = 0.
- Bytes 0x83, 0x5A -> scan_data unchanged; send 0xB0, pulse frame_done -> scan_col = 3 reads 0x5A, other columns 0x00, swap_pending clears on that cycle.
- 0x90 followed by 16 bytes 0x00..0x0F, then 0xB0 + frame_done -> scan_data[c] = c for c = 0..15; busy is high from the 0x90 until the 16th byte, then IDLE; a 17th byte 0x33 is decoded as a command -> cmd_err pulse.
- 0xA2 sent, rgb remains 3'b101 until a swap; then 0xB0 + frame_done -> rgb = 3'b010. SWAP byte on the same cycle as frame_done -> no toggle; toggle on the following frame_done.
- 0xC0 with rx_dv asserted 5 cycles later -> cmd_err pulse, byte dropped; after 16 cycles the back bank is all zero and busy = 0.
- Byte 0x55 in IDLE -> cmd_err pulse, no state change. Reset asserted mid-WR_ALL (after 7 data bytes) -> both banks zero, state IDLE, disp_sel = 0.
